// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SPI-mode SD card responder and its CRC7 helper.
// Holds the command indices, R1 bit positions, the FSM state type and the frame width.
package sd_spi_pkg;

    localparam int FRAME_W = 48;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC     = 3;

    typedef enum logic [2:0] {
        HUNT,
        RX,
        DECODE,
        NCR,
        TX
    } state_e;

    function automatic logic [7:0] r1_byte(input logic idle,
                                           input logic ill,
                                           input logic crc);
        logic [7:0] r;
        r             = 8'h00;
        r[R1_IDLE]    = idle;
        r[R1_ILLEGAL] = ill;
        r[R1_CRC]     = crc;
        return r;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled cycle, MSB of the message first.
// Ports: clock, reset (async, active-low), clr (sync clear), en, din, crc (running remainder).
module sd_crc7 (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = din ^ crc_q[6];
        crc_d = crc_q;
        if (clr) begin
            crc_d = 7'h00;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_spi_responder.sv
// Card side of an SPI-mode SD link: decodes 48-bit command frames, answers R1/R3/R7.
// Ports: clock, reset (async, active-low), io_spi_cs/sck/mosi in, io_spi_miso out,
// io_cmd_valid/io_cmd_index/io_cmd_arg (last decoded command), io_idle.
// Build option: SD_CRC_CHECK_EN enables CRC7 checking of incoming frames.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int          NCR_BYTES    = 1,
    parameter int          INIT_RETRIES = 2,
    parameter logic [31:0] OCR_VALUE    = 32'h40FF8000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_spi_cs,
    input  logic        io_spi_sck,
    input  logic        io_spi_mosi,
    output logic        io_spi_miso,
    output logic        io_cmd_valid,
    output logic [5:0]  io_cmd_index,
    output logic [31:0] io_cmd_arg,
    output logic        io_idle
);

    logic cs_s1_q, cs_s2_q;
    logic sck_s1_q, sck_s2_q, sck_d1_q;
    logic mosi_s1_q, mosi_s2_q;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [5:0]           rx_cnt_q, rx_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0]           byte_cnt_q, byte_cnt_d;
    logic [39:0]          resp_q, resp_d;
    logic [2:0]           resp_len_q, resp_len_d;
    logic                 miso_q, miso_d;
    logic                 valid_q, valid_d;
    logic [5:0]           index_q, index_d;
    logic [31:0]          arg_q, arg_d;
    logic                 idle_q, idle_d;
    logic [3:0]           init_cnt_q, init_cnt_d;
    logic                 app_q, app_d;

    logic                 sck_rise, sck_fall, cs_n;
    logic [5:0]           cmd_idx;
    logic [31:0]          cmd_arg;
    logic                 crc_err;
    logic [7:0]           r1;
    logic                 ill, idle_n, is_r7, is_r3;

    assign sck_rise = sck_s2_q & ~sck_d1_q;
    assign sck_fall = ~sck_s2_q & sck_d1_q;
    assign cs_n     = cs_s2_q;
    assign cmd_idx  = shift_q[45:40];
    assign cmd_arg  = shift_q[39:8];

`ifdef SD_CRC_CHECK_EN
    logic [6:0] crc_val;
    logic       crc_clr, crc_en;
    logic       unused_start;

    // Start bit is 0, so clearing during HUNT is equivalent to feeding it.
    assign crc_clr = (state_q == HUNT) | cs_n;
    assign crc_en  = (state_q == RX) & sck_rise & ~cs_n & (rx_cnt_q < 6'd40);

    sd_crc7 u_crc7 (
        .clock (clock),
        .reset (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (mosi_s2_q),
        .crc   (crc_val)
    );

    assign crc_err      = (crc_val != shift_q[7:1]);
    assign unused_start = shift_q[47];
`else
    logic unused_bits;
    assign crc_err     = 1'b0;
    assign unused_bits = ^{shift_q[47], shift_q[7:1]};
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rx_cnt_d   = rx_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        resp_d     = resp_q;
        resp_len_d = resp_len_q;
        miso_d     = miso_q;
        valid_d    = 1'b0;
        index_d    = index_q;
        arg_d      = arg_q;
        idle_d     = idle_q;
        init_cnt_d = init_cnt_q;
        app_d      = app_q;
        r1         = 8'h00;
        ill        = 1'b0;
        idle_n     = idle_q;
        is_r7      = 1'b0;
        is_r3      = 1'b0;

        if (cs_n) begin
            // Deselect aborts anything in flight; card state survives.
            state_d    = HUNT;
            miso_d     = 1'b1;
            rx_cnt_d   = 6'd0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (sck_rise && !mosi_s2_q) begin
                        shift_d  = {shift_q[FRAME_W-2:0], 1'b0};
                        rx_cnt_d = 6'd1;
                        state_d  = RX;
                    end
                end
                RX: begin
                    if (sck_rise) begin
                        shift_d = {shift_q[FRAME_W-2:0], mosi_s2_q};
                        if (rx_cnt_q == 6'(FRAME_W - 1)) begin
                            rx_cnt_d = 6'd0;
                            state_d  = DECODE;
                        end else begin
                            rx_cnt_d = rx_cnt_q + 6'd1;
                        end
                    end
                end
                DECODE: begin
                    state_d = HUNT;
                    if (shift_q[46] && shift_q[0]) begin
                        valid_d    = 1'b1;
                        index_d    = cmd_idx;
                        arg_d      = cmd_arg;
                        state_d    = NCR;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 4'd0;
                        resp_len_d = 3'd1;
                        if (crc_err) begin
                            r1     = r1_byte(idle_q, 1'b0, 1'b1);
                            resp_d = {r1, 32'h0};
                        end else begin
                            app_d = 1'b0;
                            unique case (1'b1)
                                cmd_idx == CMD0: begin
                                    idle_n     = 1'b1;
                                    init_cnt_d = 4'(INIT_RETRIES);
                                end
                                cmd_idx == CMD8:  is_r7 = 1'b1;
                                cmd_idx == CMD55: app_d = 1'b1;
                                cmd_idx == CMD41 && app_q: begin
                                    if (init_cnt_q != 4'd0) begin
                                        init_cnt_d = init_cnt_q - 4'd1;
                                    end
                                    if (init_cnt_q <= 4'd1) begin
                                        idle_n = 1'b0;
                                    end
                                end
                                cmd_idx == CMD58: is_r3 = 1'b1;
                                default:          ill = 1'b1;
                            endcase
                            idle_d = idle_n;
                            r1     = r1_byte(idle_n, ill, 1'b0);
                            if (is_r7) begin
                                resp_d     = {r1, 16'h0000, 4'h0, cmd_arg[11:0]};
                                resp_len_d = 3'd5;
                            end else if (is_r3) begin
                                resp_d     = {r1, ~idle_q, OCR_VALUE[30:0]};
                                resp_len_d = 3'd5;
                            end else begin
                                resp_d = {r1, 32'h0};
                            end
                        end
                    end
                end
                NCR: begin
                    if (sck_fall) begin
                        miso_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q == 4'(NCR_BYTES - 1)) begin
                                byte_cnt_d = 4'd0;
                                state_d    = TX;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 4'd1;
                            end
                        end
                    end
                end
                TX: begin
                    if (sck_fall) begin
                        // One extra fall after the last bit releases the line.
                        if ({1'b0, resp_len_q} == byte_cnt_q) begin
                            miso_d     = 1'b1;
                            bit_cnt_d  = 3'd0;
                            byte_cnt_d = 4'd0;
                            state_d    = HUNT;
                        end else begin
                            miso_d    = resp_q[39];
                            resp_d    = {resp_q[38:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                byte_cnt_d = byte_cnt_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_d1_q   <= 1'b0;
            mosi_s1_q  <= 1'b1;
            mosi_s2_q  <= 1'b1;
            state_q    <= HUNT;
            shift_q    <= '0;
            rx_cnt_q   <= 6'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 4'd0;
            resp_q     <= 40'h0;
            resp_len_q <= 3'd0;
            miso_q     <= 1'b1;
            valid_q    <= 1'b0;
            index_q    <= 6'd0;
            arg_q      <= 32'h0;
            idle_q     <= 1'b1;
            init_cnt_q <= 4'(INIT_RETRIES);
            app_q      <= 1'b0;
        end else begin
            cs_s1_q    <= io_spi_cs;
            cs_s2_q    <= cs_s1_q;
            sck_s1_q   <= io_spi_sck;
            sck_s2_q   <= sck_s1_q;
            sck_d1_q   <= sck_s2_q;
            mosi_s1_q  <= io_spi_mosi;
            mosi_s2_q  <= mosi_s1_q;
            state_q    <= state_d;
            shift_q    <= shift_d;
            rx_cnt_q   <= rx_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            resp_q     <= resp_d;
            resp_len_q <= resp_len_d;
            miso_q     <= miso_d;
            valid_q    <= valid_d;
            index_q    <= index_d;
            arg_q      <= arg_d;
            idle_q     <= idle_d;
            init_cnt_q <= init_cnt_d;
            app_q      <= app_d;
        end
    end

    assign io_spi_miso  = miso_q;
    assign io_cmd_valid = valid_q;
    assign io_cmd_index = index_q;
    assign io_cmd_arg   = arg_q;
    assign io_idle      = idle_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: table of command frames with expected
// responses, plus hand sequences for deselect abort, bad end bit and async reset.
module tb_sd_spi_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cs    = 1'b1;
    logic        sck   = 1'b0;
    logic        mosi  = 1'b1;
    logic        miso;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        idle;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    sd_spi_responder dut (
        .clock        (clock),
        .reset        (reset),
        .io_spi_cs    (cs),
        .io_spi_sck   (sck),
        .io_spi_mosi  (mosi),
        .io_spi_miso  (miso),
        .io_cmd_valid (cmd_valid),
        .io_cmd_index (cmd_index),
        .io_cmd_arg   (cmd_arg),
        .io_idle      (idle)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (cmd_valid === 1'b1) pulses++;
    end

    typedef struct {
        logic [47:0] cmd;
        int          rlen;
        logic [39:0] resp;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        idle;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [39:0] act,
                         input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bit_clk(input logic b, output logic r);
        mosi = b;
        wait_clk(4);
        sck = 1'b1;
        wait_clk(4);
        r   = miso;
        sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            bit_clk(tx[i], rx[i]);
        end
    endtask

    task automatic send_frame(input logic [47:0] f);
        logic [7:0] b;
        for (int i = 5; i >= 0; i--) begin
            xfer(f[i*8 +: 8], b);
        end
    endtask

    task automatic run_vec(input int k);
        logic [7:0]  b;
        logic [39:0] got;
        int          p0;
        p0 = pulses;
        send_frame(vecs[k].cmd);
        xfer(8'hFF, b);
        check($sformatf("v%0d_ncr", k), {32'h0, b}, 40'hFF);
        got = '0;
        for (int i = 0; i < vecs[k].rlen; i++) begin
            xfer(8'hFF, b);
            got[39 - 8*i -: 8] = b;
        end
        check($sformatf("v%0d_resp", k), got, vecs[k].resp);
        xfer(8'hFF, b);
        check($sformatf("v%0d_tail", k), {32'h0, b}, 40'hFF);
        check($sformatf("v%0d_pulse", k), 40'(pulses - p0), 40'd1);
        check($sformatf("v%0d_index", k), {34'h0, cmd_index}, {34'h0, vecs[k].idx});
        check($sformatf("v%0d_arg", k), {8'h0, cmd_arg}, {8'h0, vecs[k].arg});
        check($sformatf("v%0d_idle", k), {39'h0, idle}, {39'h0, vecs[k].idle});
    endtask

    initial begin
        logic [7:0] b;
        logic       r;
        logic [7:0] crc_r1;
        int         p0;

`ifdef SD_CRC_CHECK_EN
        crc_r1 = 8'h09;
`else
        crc_r1 = 8'h01;
`endif

        vecs[0]  = '{48'h400000000095, 1, {8'h01, 32'h0}, 6'd0, 32'h0, 1'b1};
        vecs[1]  = '{48'h48000001AA87, 5, 40'h01000001AA, 6'd8, 32'h1AA, 1'b1};
        vecs[2]  = '{48'h7A00000000FD, 5, 40'h0140FF8000, 6'd58, 32'h0, 1'b1};
        vecs[3]  = '{48'h510000000055, 1, {8'h05, 32'h0}, 6'd17, 32'h0, 1'b1};
        vecs[4]  = '{48'h6900000000E5, 1, {8'h05, 32'h0}, 6'd41, 32'h0, 1'b1};
        vecs[5]  = '{48'h400000000001, 1, {crc_r1, 32'h0}, 6'd0, 32'h0, 1'b1};
        vecs[6]  = '{48'h770000000065, 1, {8'h01, 32'h0}, 6'd55, 32'h0, 1'b1};
        vecs[7]  = '{48'h6900000000E5, 1, {8'h01, 32'h0}, 6'd41, 32'h0, 1'b1};
        vecs[8]  = '{48'h770000000065, 1, {8'h01, 32'h0}, 6'd55, 32'h0, 1'b1};
        vecs[9]  = '{48'h6900000000E5, 1, {8'h00, 32'h0}, 6'd41, 32'h0, 1'b0};
        vecs[10] = '{48'h7A00000000FD, 5, 40'h00C0FF8000, 6'd58, 32'h0, 1'b0};

        wait_clk(3);
        check("rst_miso", {39'h0, miso}, 40'h1);
        check("rst_valid", {39'h0, cmd_valid}, 40'h0);
        check("rst_index", {34'h0, cmd_index}, 40'h0);
        check("rst_arg", {8'h0, cmd_arg}, 40'h0);
        check("rst_idle", {39'h0, idle}, 40'h1);
        reset = 1'b1;
        wait_clk(4);
        cs = 1'b0;
        wait_clk(4);

        for (int k = 0; k < 11; k++) begin
            run_vec(k);
        end

        // Async reset in the middle of a CMD58 response (card is ready, R1 = 00).
        send_frame(48'h7A00000000FD);
        xfer(8'hFF, b);
        for (int i = 0; i < 3; i++) begin
            bit_clk(1'b1, r);
        end
        wait_clk(4);
        check("tx_miso_low", {39'h0, miso}, 40'h0);
        reset = 1'b0;
        #1;
        check("arst_miso", {39'h0, miso}, 40'h1);
        check("arst_idle", {39'h0, idle}, 40'h1);
        check("arst_index", {34'h0, cmd_index}, 40'h0);
        check("arst_valid", {39'h0, cmd_valid}, 40'h0);
        cs  = 1'b1;
        sck = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        wait_clk(4);
        cs = 1'b0;
        wait_clk(4);

        // Deselect after three bytes of CMD0: no pulse, line released.
        p0 = pulses;
        xfer(8'h40, b);
        xfer(8'h00, b);
        xfer(8'h00, b);
        cs = 1'b1;
        wait_clk(8);
        check("abort_miso", {39'h0, miso}, 40'h1);
        check("abort_pulse", 40'(pulses - p0), 40'd0);
        check("abort_idle", {39'h0, idle}, 40'h1);
        cs = 1'b0;
        wait_clk(4);
        run_vec(0);

        // End bit 0: frame discarded silently.
        p0 = pulses;
        send_frame(48'h400000000094);
        xfer(8'hFF, b);
        check("badend_b0", {32'h0, b}, 40'hFF);
        xfer(8'hFF, b);
        check("badend_b1", {32'h0, b}, 40'hFF);
        check("badend_pulse", 40'(pulses - p0), 40'd0);

        // Link still usable afterwards.
        run_vec(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
